// File: rtl/mem_arb_ram_pkg.sv
// Shared defaults, request record and helpers for the arbitrated RAM.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_CH = 2;
    localparam int MAX_CH     = 8;

    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic logic [MAX_CH-1:0] onehot(input int unsigned idx);
        return MAX_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/mem_arb_ram_if.sv
// Per-channel request handshake and shared read-response bus.
interface mem_arb_ram_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH
);
    logic [NUM_CH-1:0]             req_valid;
    logic [NUM_CH-1:0]             req_ready;
    logic [NUM_CH-1:0]             req_write;
    logic [NUM_CH-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_CH-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_CH-1:0]             rsp_valid;
    logic [DATA_W-1:0]             rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_arb_ram_rr_arbiter.sv
// Round-robin arbiter: search begins one past the last granted channel and wraps.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N = DEF_NUM_CH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(N - 1);

    logic [PTR_W-1:0]  last_q;
    logic [PTR_W-1:0]  last_d;
    logic [PTR_W-1:0]  idx;
    logic [MAX_CH-1:0] oh;
    logic              found;

    // advance low blanks every grant and freezes the pointer
    always_comb begin
        last_d = last_q;
        idx    = '0;
        oh     = '0;
        found  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = PTR_W'((int'(last_q) + k) % N);
            if (!found && advance && req[idx]) begin
                found  = 1'b1;
                last_d = idx;
                oh     = onehot(32'(idx));
            end
        end
        gnt = oh[N-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= LAST_CH;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/mem_arb_ram.sv
// Single-port RAM shared by NUM_CH requesters; reads answer one cycle after grant.
module mem_arb_ram
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic          clk,
    input  logic          rst,
    mem_arb_ram_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [NUM_CH-1:0] gnt;
    logic              any_gnt;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [NUM_CH-1:0] rsp_valid_d;
    logic [NUM_CH-1:0] rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    // No grants while reset is held, so nothing is accepted during reset
    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (!rst),
        .gnt     (gnt)
    );

    assign any_gnt = |gnt;

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                sel_write = bus.req_write[i];
                sel_addr  = bus.req_addr[i];
                sel_wdata = bus.req_wdata[i];
            end
        end
    end

    // Reads see a write committed on the previous edge
    always_comb begin
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        if (any_gnt && !sel_write) begin
            rsp_valid_d = gnt;
            rsp_rdata_d = mem[sel_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (any_gnt && sel_write) begin
            mem[sel_addr] <= sel_wdata;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_mem_arb_ram.sv
// Scoreboard bench for mem_arb_ram in two configurations: 5/8/2 and 4/16/4.
module tb_mem_arb_ram;

    typedef struct {
        int          due;
        int          ch;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic [7:0]  drv_valid [2];
    logic [7:0]  drv_write [2];
    logic [4:0]  drv_addr  [2][8];
    logic [15:0] drv_wdata [2][8];
    logic        rst_g     [2];
    logic [7:0]  granted   [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ch(input int g, input int c, input bit v, input bit w,
                          input int a, input logic [15:0] d);
        drv_valid[g][c] = v;
        drv_write[g][c] = w;
        drv_addr[g][c]  = 5'(a);
        drv_wdata[g][c] = d;
    endtask

    task automatic rand_run(input int g, input int ncyc);
        int nch;
        int aw;
        nch = (g == 0) ? 2 : 4;
        aw  = (g == 0) ? 5 : 4;
        for (int n = 0; n < ncyc; n++) begin
            for (int c = 0; c < nch; c++) begin
                if (!drv_valid[g][c] || granted[g][c]) begin
                    drv_valid[g][c] = ($urandom_range(0, 3) != 0);
                    drv_write[g][c] = ($urandom_range(0, 2) == 0);
                    drv_addr[g][c]  = 5'($urandom_range(0, (1 << aw) - 1));
                    drv_wdata[g][c] = 16'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    drv_valid[g][c] = 1'b0;
                end
            end
            tick(1);
        end
        drv_valid[g] = '0;
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int AW  = (g == 0) ? 5 : 4;
        localparam int DW  = (g == 0) ? 8 : 16;
        localparam int NCH = (g == 0) ? 2 : 4;

        mem_arb_ram_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NCH)) ifc ();

        mem_arb_ram #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NCH)) dut (
            .clk (clk),
            .rst (rst_g[g]),
            .bus (ifc.slave)
        );

        for (genvar c = 0; c < NCH; c++) begin : drv
            assign ifc.req_valid[c] = drv_valid[g][c];
            assign ifc.req_write[c] = drv_write[g][c];
            assign ifc.req_addr[c]  = drv_addr[g][c][AW-1:0];
            assign ifc.req_wdata[c] = drv_wdata[g][c][DW-1:0];
        end

        exp_t        q [$];
        int          mptr;
        logic [15:0] mmem [32];
        logic [15:0] last_data;

        // Monitor: response is due exactly one cycle after a read grant
        always @(negedge clk) begin : mon_p
            exp_t e;
            if (!rst_g[g]) begin
                if (q.size() != 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    chk($sformatf("cfg%0d rsp_valid", g), 32'(ifc.rsp_valid), 32'(1) << e.ch);
                    chk($sformatf("cfg%0d rsp_rdata", g), 32'(ifc.rsp_rdata), 32'(e.data));
                    last_data = e.data;
                end else begin
                    chk($sformatf("cfg%0d rsp_idle", g), 32'(ifc.rsp_valid), 32'd0);
                    chk($sformatf("cfg%0d rsp_hold", g), 32'(ifc.rsp_rdata), 32'(last_data));
                end
            end
        end

        // Reference model: round-robin pick, word memory, expected-response queue
        always begin : model_p
            int          gch;
            int          a;
            logic [7:0]  exp_rdy;
            @(negedge clk);
            #2;
            if (rst_g[g]) begin
                q.delete();
                mptr       = NCH - 1;
                last_data  = '0;
                granted[g] = '0;
            end else begin
                gch = -1;
                for (int k = 1; k <= NCH; k++) begin
                    if (gch < 0 && drv_valid[g][(mptr + k) % NCH]) gch = (mptr + k) % NCH;
                end
                exp_rdy = (gch >= 0) ? (8'd1 << gch) : 8'd0;
                chk($sformatf("cfg%0d req_ready", g), 32'(ifc.req_ready), 32'(exp_rdy));
                granted[g] = exp_rdy;
                if (gch >= 0) begin
                    mptr = gch;
                    a = int'(drv_addr[g][gch]) % (1 << AW);
                    if (drv_write[g][gch]) begin
                        mmem[a] = drv_wdata[g][gch] & 16'((1 << DW) - 1);
                    end else begin
                        q.push_back('{cyc + 1, gch, mmem[a]});
                    end
                end
            end
        end
    end

    initial begin
        for (int g = 0; g < 2; g++) begin
            drv_valid[g] = '0;
            drv_write[g] = '0;
            granted[g]   = '0;
            rst_g[g]     = 1'b1;
            for (int c = 0; c < 8; c++) begin
                drv_addr[g][c]  = '0;
                drv_wdata[g][c] = '0;
            end
        end
        tick(2);

        // Reset state with requests pending
        drv_valid[0] = 8'h03;
        drv_valid[1] = 8'h0f;
        #1;
        chk("cfg0 reset req_ready", 32'(cfg[0].ifc.req_ready), 32'd0);
        chk("cfg0 reset rsp_valid", 32'(cfg[0].ifc.rsp_valid), 32'd0);
        chk("cfg0 reset rsp_rdata", 32'(cfg[0].ifc.rsp_rdata), 32'd0);
        chk("cfg1 reset req_ready", 32'(cfg[1].ifc.req_ready), 32'd0);
        chk("cfg1 reset rsp_valid", 32'(cfg[1].ifc.rsp_valid), 32'd0);
        drv_valid[0] = '0;
        drv_valid[1] = '0;
        tick(1);
        rst_g[0] = 1'b0;
        rst_g[1] = 1'b0;

        // Channel 0 writes then reads address 3
        set_ch(0, 0, 1, 1, 3, 16'hA5);
        tick(1);
        set_ch(0, 0, 1, 0, 3, 16'h0);
        tick(1);
        drv_valid[0] = '0;
        tick(2);

        // Preload, alternating channels so channel 1 is granted last
        for (int a = 0; a < 32; a++) begin
            set_ch(0, a % 2, 1, 1, a,
                   (a == 0) ? 16'h11 : (a == 1) ? 16'h22 : (a == 3) ? 16'hA5 : 16'($urandom_range(0, 255)));
            tick(1);
            drv_valid[0] = '0;
        end

        // Both channels reading continuously: grants alternate 0,1,...
        set_ch(0, 0, 1, 0, 0, 16'h0);
        set_ch(0, 1, 1, 0, 1, 16'h0);
        tick(6);
        drv_valid[0] = '0;

        // Idle gap leaves the pointer on channel 1, so channel 0 wins next
        tick(3);
        set_ch(0, 0, 1, 0, 0, 16'h0);
        set_ch(0, 1, 1, 0, 1, 16'h0);
        tick(2);
        drv_valid[0] = '0;

        // Write by channel 0, read of the same word by channel 1 next cycle
        set_ch(0, 0, 1, 1, 31, 16'h5C);
        tick(1);
        drv_valid[0] = '0;
        set_ch(0, 1, 1, 0, 31, 16'h0);
        tick(1);
        drv_valid[0] = '0;
        tick(2);

        // Reset in the cycle the read response is presented
        set_ch(0, 0, 1, 0, 3, 16'h0);
        tick(1);
        drv_valid[0] = '0;
        chk("cfg0 rsp_valid before reset", 32'(cfg[0].ifc.rsp_valid), 32'd1);
        chk("cfg0 rsp_rdata before reset", 32'(cfg[0].ifc.rsp_rdata), 32'hA5);
        rst_g[0] = 1'b1;
        #1;
        chk("cfg0 rsp_valid in reset", 32'(cfg[0].ifc.rsp_valid), 32'd0);
        chk("cfg0 rsp_rdata in reset", 32'(cfg[0].ifc.rsp_rdata), 32'd0);
        drv_valid[0] = 8'h03;
        #1;
        chk("cfg0 req_ready in reset", 32'(cfg[0].ifc.req_ready), 32'd0);
        drv_valid[0] = '0;
        tick(2);
        rst_g[0] = 1'b0;
        set_ch(0, 0, 1, 0, 0, 16'h0);
        set_ch(0, 1, 1, 0, 1, 16'h0);
        tick(2);
        drv_valid[0] = '0;
        tick(2);

        rand_run(0, 300);
        tick(3);

        // Four-channel configuration: preload, then all four reading their own word
        for (int a = 0; a < 16; a++) begin
            set_ch(1, a % 4, 1, 1, a, 16'($urandom));
            tick(1);
            drv_valid[1] = '0;
        end
        for (int c = 0; c < 4; c++) set_ch(1, c, 1, 0, c, 16'h0);
        tick(8);
        drv_valid[1] = '0;
        tick(2);

        rand_run(1, 300);
        tick(3);

        chk("cfg0 responses drained", 32'(cfg[0].q.size()), 32'd0);
        chk("cfg1 responses drained", 32'(cfg[1].q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arb_ram.md
# mem_arb_ram

Parametrised single-port synchronous RAM shared by NUM_CH requesters through a round-robin arbiter. It succeeds the fixed 32x8 read/write memory. It adds configurable width and depth, a valid/ready request handshake per channel, and a registered one-cycle read response routed back to the granted channel. It sits between several test or master agents and a common storage array.

## Interface
Parameters:
- ADDR_W, 5, address width; depth = 2**ADDR_W words
- DATA_W, 8, data word width
- NUM_CH, 2, number of requesting channels (1..8)

Ports (reset is asynchronous and active-high):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_CH  per-channel request present
- req_ready  out  NUM_CH  per-channel grant; transfer when valid && ready
- req_write  in  NUM_CH  1 = write, 0 = read
- req_addr  in  NUM_CH x ADDR_W  per-channel address
- req_wdata  in  NUM_CH x DATA_W  per-channel write data
- rsp_valid  out  NUM_CH  one-hot; read data valid for that channel
- rsp_rdata  out  DATA_W  read data, shared by all channels

## Operation
- Arbiter: each cycle it grants at most one channel with req_valid=1.
  - Search starts at channel (last_grant+1) mod NUM_CH and wraps.
  - req_ready is combinational from req_valid and the pointer.
  - req_ready[i] is 0 whenever req_valid[i] is 0.
- Pointer: last_grant updates only in cycles with a grant. Idle cycles leave it unchanged.
- Write: on a granted write, mem[addr] <= wdata at that edge. No response is generated.
- Read: on a granted read, at that edge:
  - mem[addr] is registered into rsp_rdata;
  - rsp_valid is set to the one-hot of the granted channel.
- rsp_valid and rsp_rdata hold for exactly one cycle.
- When no read is granted, rsp_valid = 0 and rsp_rdata holds its last value.
- Requesters must hold valid, write, addr and wdata stable until ready. Dropping valid before ready is legal and simply withdraws the request.
- Fairness: a continuously valid channel is granted within NUM_CH cycles.
- Write then read of the same address in consecutive cycles returns the new data.
- NUM_CH=1 degenerates to ready = valid.

## Timing
- Reset values (asynchronous, while rst=1):
  - rsp_valid = 0, rsp_rdata = 0;
  - last_grant = NUM_CH-1, so channel 0 has first priority after reset;
  - req_ready = 0.
- Memory array contents are not reset.
- Read latency: response in the cycle after the grant edge (1 clk). Write latency: data visible to a read granted in the next cycle.
- Throughput: one transfer per cycle, aggregate over all channels.
- Reset asserted mid-operation:
  - a response due on the next edge is dropped (rsp_valid forced 0);
  - a write granted in the same cycle as reset assertion is not guaranteed;
  - the arbiter pointer returns to its reset state.
- Simultaneous valid on all channels with a continuous load: grants rotate 0,1,...,NUM_CH-1,0,...

## Structure
- Package mem_arb_pkg:
  - default ADDR_W/DATA_W/NUM_CH localparams;
  - typedef mem_req_t (write, addr, wdata);
  - function onehot(idx).
- Sub-module rr_arbiter #(N): inputs req[N], advance; outputs gnt[N] one-hot; holds the rotating pointer.
- Top-level mem_arb_ram contains:
  - the request mux selected by gnt;
  - the storage array logic [DATA_W-1:0] mem[2**ADDR_W];
  - the response register.

## Test plan
- Reset release, single channel 0: write addr 3 = 8'hA5, then read addr 3 -> rsp_valid=2'b01 one cycle later, rsp_rdata=8'hA5.
- Both channels valid continuously, reading addr 0 (ch0) and addr 1 (ch1), preloaded 8'h11/8'h22:
  - grants alternate ch0, ch1, ch0, ...;
  - responses alternate 01/8'h11 and 10/8'h22 every cycle.
- Idle gap: ch1 granted, 3 idle cycles, then both valid -> ch0 granted first (pointer unchanged during idle).
- Back-to-back write/read: ch0 writes addr 31 = 8'h5C, next cycle ch1 reads addr 31 -> rsp_valid=2'b10, rsp_rdata=8'h5C.
- Reset mid-read: assert rst in the cycle after a granted read -> rsp_valid=0 immediately; after release channel 0 has first priority.
- Parameter sweep ADDR_W=4, DATA_W=16, NUM_CH=4, all four channels valid -> grants in order 0,1,2,3,0, each read returns its own 16-bit data.
